// File: rtl/video_timing_gen.sv
// Raster timing generator: scan counters, registered sync/DE/frame strobes and
// a ce-qualified delay line that aligns sync/DE with frame-buffer read latency.
module video_timing_gen #(
  parameter int   H_ACTIVE = 1280,
  parameter int   H_FP     = 110,
  parameter int   H_SYNC   = 40,
  parameter int   H_BP     = 220,
  parameter int   V_ACTIVE = 720,
  parameter int   V_FP     = 5,
  parameter int   V_SYNC   = 5,
  parameter int   V_BP     = 20,
  parameter logic SYNC_POL = 1'b1,
  parameter int   DELAY    = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ce_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        active_draw_out,
  output logic        new_frame_out,
  output logic [5:0]  frame_count_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 2048 || V_TOTAL > 1024) begin : g_param_check
    $error("video_timing_gen: H_TOTAL must be <= 2048 and V_TOTAL <= 1024");
  end

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [10:0] h_next;
  logic [9:0]  v_next;
  logic        hsync_next;
  logic        vsync_next;
  logic        active_next;
  logic        new_frame_next;
  logic        hsync_r;
  logic        vsync_r;

  // All decodes look at the next position so strobes line up with the counters.
  always_comb begin
    h_next = hcount_out;
    v_next = vcount_out;
    if (hcount_out == H_LAST) begin
      h_next = '0;
      if (vcount_out == V_LAST) v_next = '0;
      else                      v_next = vcount_out + 10'd1;
    end else begin
      h_next = hcount_out + 11'd1;
    end
    hsync_next     = ((h_next >= HS_START) && (h_next <= HS_END)) ? SYNC_POL : ~SYNC_POL;
    vsync_next     = ((v_next >= VS_START) && (v_next <= VS_END)) ? SYNC_POL : ~SYNC_POL;
    active_next    = (h_next < H_ACT) && (v_next < V_ACT);
    new_frame_next = (h_next == H_ACT) && (v_next == V_ACT);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hcount_out      <= H_LAST;
      vcount_out      <= V_LAST;
      active_draw_out <= 1'b0;
      new_frame_out   <= 1'b0;
      frame_count_out <= '0;
      hsync_r         <= ~SYNC_POL;
      vsync_r         <= ~SYNC_POL;
    end else if (ce_in) begin
      hcount_out      <= h_next;
      vcount_out      <= v_next;
      active_draw_out <= active_next;
      new_frame_out   <= new_frame_next;
      hsync_r         <= hsync_next;
      vsync_r         <= vsync_next;
      if (new_frame_next) frame_count_out <= frame_count_out + 6'd1;
    end else begin
      new_frame_out <= 1'b0;
    end
  end

  if (DELAY == 0) begin : g_no_delay
    assign hsync_out = hsync_r;
    assign vsync_out = vsync_r;
    assign de_out    = active_draw_out;
  end else begin : g_delay
    // Each stage holds {hsync, vsync, de}.
    logic [2:0] dly_q [DELAY];

    always_ff @(posedge clk_in) begin
      if (!rst_in) begin
        for (int i = 0; i < DELAY; i++) dly_q[i] <= {~SYNC_POL, ~SYNC_POL, 1'b0};
      end else if (ce_in) begin
        dly_q[0] <= {hsync_r, vsync_r, active_draw_out};
        for (int i = 1; i < DELAY; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign hsync_out = dly_q[DELAY-1][2];
    assign vsync_out = dly_q[DELAY-1][1];
    assign de_out    = dly_q[DELAY-1][0];
  end

endmodule
